// File: rtl/drum_denorm_pipe.sv
// DRUM denormaliser: encodes both leading-one vectors into a shift amount and
// restores the truncated KxK product to a 2N-bit result over a 2-stage valid/ready pipe.
module drum_denorm_pipe #(
   parameter int N = 16,
   parameter int K = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     lod_a,
   input  logic [N-1:0]     lod_b,
   input  logic [2*K-1:0]   prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   result,
   output logic             onehot_err
);
   localparam int SW = $clog2(2*N);

   // Highest set bit wins, so a corrupted vector still yields a usable shift.
   function automatic logic [SW-1:0] lod_shift(input logic [N-1:0] v);
      logic [SW-1:0] pos;
      pos = '0;
      for (int i = 0; i < N; i++)
         if (v[i]) pos = SW'(i);
      return (pos >= SW'(K-1)) ? pos - SW'(K-1) : '0;
   endfunction

   function automatic logic multi_hot(input logic [N-1:0] v);
      return |(v & (v - N'(1)));
   endfunction

   logic              s1_valid_q, s1_valid_d;
   logic [2*K-1:0]    s1_prod_q, s1_prod_d;
   logic [SW-1:0]     s1_shift_q, s1_shift_d;
   logic              s1_zero_q, s1_zero_d;
   logic              s1_err_q, s1_err_d;
   logic              s2_valid_q, s2_valid_d;
   logic [2*N-1:0]    result_q, result_d;
   logic              err_q, err_d;

   logic              s2_load;
   logic              accept;
   logic [2*N-1:0]    prod_ext;

   assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | s2_load;
   assign accept   = in_valid & in_ready;
   assign prod_ext = (2*N)'(s1_prod_q);

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_prod_d  = s1_prod_q;
      s1_shift_d = s1_shift_q;
      s1_zero_d  = s1_zero_q;
      s1_err_d   = s1_err_q;
      s2_valid_d = s2_valid_q;
      result_d   = result_q;
      err_d      = err_q;

      if (accept) begin
         s1_valid_d = 1'b1;
         s1_prod_d  = prod;
         s1_shift_d = lod_shift(lod_a) + lod_shift(lod_b);
         s1_zero_d  = (lod_a == '0) | (lod_b == '0);
         s1_err_d   = multi_hot(lod_a) | multi_hot(lod_b);
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load) begin
         s2_valid_d = 1'b1;
         result_d   = s1_zero_q ? '0 : (prod_ext << s1_shift_q);
         err_d      = s1_err_q;
      end else if (out_ready) begin
         s2_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_prod_q  <= '0;
         s1_shift_q <= '0;
         s1_zero_q  <= 1'b0;
         s1_err_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         result_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_prod_q  <= s1_prod_d;
         s1_shift_q <= s1_shift_d;
         s1_zero_q  <= s1_zero_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         result_q   <= result_d;
         err_q      <= err_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign result     = result_q;
   assign onehot_err = err_q;
endmodule

// File: tb/tb_drum_denorm_pipe.sv
// Directed bench for drum_denorm_pipe (N=16, K=6): single beats, streaming under
// back-pressure with an ordered scoreboard, and reset with beats in flight.
module tb_drum_denorm_pipe;
   logic        clk, rst_n;
   logic        in_valid, in_ready;
   logic [15:0] lod_a, lod_b;
   logic [11:0] prod;
   logic        out_valid, out_ready;
   logic [31:0] result;
   logic        onehot_err;

   int n_chk  = 0;
   int n_fail = 0;

   drum_denorm_pipe #(.N(16), .K(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .lod_a(lod_a), .lod_b(lod_b), .prod(prod),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .onehot_err(onehot_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One isolated beat with out_ready high: result must appear exactly 2 edges after accept.
   task automatic one_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [11:0] p, input logic [31:0] exp_res, input logic exp_err);
      @(negedge clk);
      in_valid = 1'b1; lod_a = a; lod_b = b; prod = p;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_lat1_valid"}, out_valid, 1'b0);
      @(negedge clk);
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_err"}, onehot_err, exp_err);
   endtask

   initial begin
      logic [31:0] expq[$];
      logic [31:0] exp_v;
      int          sent, got, occ;
      logic        acc, fire;

      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      lod_a = '0; lod_b = '0; prod = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", result, 32'd0);
      chk("rst_err", onehot_err, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      one_beat("t1", 16'h0400, 16'h0020, 12'd1000, 32'd32000, 1'b0);
      one_beat("t2", 16'h8000, 16'h8000, 12'hFFF, 32'hFFF0_0000, 1'b0);
      one_beat("t3_zero", 16'h0000, 16'h0100, 12'h3A5, 32'd0, 1'b0);
      one_beat("t3_noshift", 16'h0010, 16'h0008, 12'd77, 32'd77, 1'b0);
      one_beat("t5_multi", 16'h0480, 16'h0002, 12'd5, 32'd160, 1'b1);
      one_beat("t5_clean", 16'h0400, 16'h0020, 12'd1000, 32'd32000, 1'b0);

      // Streaming: lod_a = 0x20<<j gives shift j, lod_b = 0x40 gives shift 1.
      @(negedge clk);
      sent = 0; got = 0; occ = 0;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         if (cyc != 0) @(negedge clk);
         out_ready = (cyc % 3 == 0);
         if (sent < 8) begin
            in_valid = 1'b1;
            lod_a = 16'h0020 << (sent % 4);
            lod_b = 16'h0040;
            prod  = 12'(100 + sent);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         chk("t4_in_ready", in_ready, !(occ == 2 && !out_ready));
         if (out_valid) begin
            if (expq.size() == 0) chk("t4_unexpected_beat", out_valid, 1'b0);
            else begin
               chk("t4_result", result, expq[0]);
               chk("t4_err", onehot_err, 1'b0);
            end
         end
         acc  = in_valid & in_ready;
         fire = out_valid & out_ready;
         exp_v = 32'(100 + sent) << ((sent % 4) + 1);
         @(posedge clk);
         if (fire && expq.size() != 0) begin
            void'(expq.pop_front());
            got++;
         end
         if (acc) begin
            expq.push_back(exp_v);
            sent++;
         end
         occ = occ + int'(acc) - int'(fire);
      end
      chk("t4_beats_out", 64'(got), 64'd8);
      chk("t4_beats_in", 64'(sent), 64'd8);

      // Two beats in flight, then asynchronous reset between edges.
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b1; lod_a = 16'h0400; lod_b = 16'h0020; prod = 12'd3;
      @(negedge clk);
      lod_a = 16'h8000; lod_b = 16'h8000; prod = 12'd1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("t6_pre_valid", out_valid, 1'b1);
      chk("t6_pre_result", result, 32'd96);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", out_valid, 1'b0);
      chk("t6_rst_result", result, 32'd0);
      chk("t6_rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      chk("t6_hold_valid", out_valid, 1'b0);
      rst_n = 1'b1;
      one_beat("t6_after", 16'h0800, 16'h0040, 12'd9, 32'd9 << 7, 1'b0);
      @(negedge clk);
      chk("t6_drained", out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
